// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional output registering is controlled by RR_MUX_OUT_REG_EN in rr_mux_arbiter.
package rr_mux_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} state_e;

  localparam int NUM_REQ = 4;

  // OR-encode a one-hot (or zero) grant vector into a mux select.
  function automatic logic [1:0] onehot_to_sel(input logic [NUM_REQ-1:0] oh);
    logic [1:0] s;
    s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) s = s | 2'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Combinational 4:1 mux: {s1,s0}=0..3 selects a..d.
module mux4to1 #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case ({s1, s0})
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request searching from last+1, wrapping to lower indices.
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         next_idx,
  output logic               found
);

  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    next_idx = '0;
    found    = 1'b0;
    // Offset 4 wraps to last itself, so the previous owner is searched last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects with bounded grant hold.
// Define RR_MUX_OUT_REG_EN to register y and y_valid (one cycle behind gnt/select).
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic               busy
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         hold_q, hold_d;
  logic [1:0]         last_q, last_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [1:0]         pick_last;
  logic [1:0]         pick_idx;
  logic               pick_found;
  logic               owner_req;
  logic [WIDTH-1:0]   y_mux;

  // While granted, the search excludes the owner and starts after it.
  assign pick_req  = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
  assign pick_last = (state_q == ST_GRANT) ? sel_q : last_q;
  assign owner_req = |(req & gnt_q);

  rr_pick4 u_pick (
    .req      (pick_req),
    .last     (pick_last),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          sel_d   = onehot_to_sel(gnt_d);
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          // Owner release takes precedence over hold expiry.
          last_d = sel_q;
          hold_d = '0;
          if (pick_found) begin
            gnt_d = NUM_REQ'(1) << pick_idx;
            sel_d = onehot_to_sel(gnt_d);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (pick_found && hold_q == HOLD_LAST) begin
          last_d = sel_q;
          hold_d = '0;
          gnt_d  = NUM_REQ'(1) << pick_idx;
          sel_d  = onehot_to_sel(gnt_d);
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  mux4to1 #(.WIDTH(WIDTH)) u_mux (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .s1 (sel_q[1]),
    .s0 (sel_q[0]),
    .y  (y_mux)
  );

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign busy = (state_q == ST_GRANT);

`ifdef RR_MUX_OUT_REG_EN
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;

  always_comb begin
    y_d       = y_mux;
    y_valid_d = |gnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
`else
  assign y       = y_mux;
  assign y_valid = |gnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed scoreboard bench for rr_mux_arbiter (default build, MAX_HOLD=4).
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] a, b, c, d;
  logic [3:0] gnt;
  logic       s1, s0;
  logic [1:0] y;
  logic       y_valid, busy;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic [1:0] din [4];

  rr_mux_arbiter #(.WIDTH(2), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .gnt     (gnt),
    .s1      (s1),
    .s0      (s0),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t  e;
    string t;
    logic  e_v;
    logic [1:0] e_y;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e   = sb_q.pop_front();
    t   = tag_q.pop_front();
    e_v = |e.gnt;
    e_y = din[e.sel];
    vectors++;
    assert (gnt === e.gnt) else begin
      miscompares++;
      $error("FAIL %s gnt: got %b want %b", t, gnt, e.gnt);
    end
    vectors++;
    assert ({s1, s0} === e.sel) else begin
      miscompares++;
      $error("FAIL %s sel: got %b want %b", t, {s1, s0}, e.sel);
    end
    vectors++;
    assert (y_valid === e_v) else begin
      miscompares++;
      $error("FAIL %s y_valid: got %b want %b", t, y_valid, e_v);
    end
    vectors++;
    assert (busy === e_v) else begin
      miscompares++;
      $error("FAIL %s busy: got %b want %b", t, busy, e_v);
    end
    vectors++;
    assert (y === e_y) else begin
      miscompares++;
      $error("FAIL %s y: got %b want %b", t, y, e_y);
    end
    $display("step %-10s req=%b rst_n=%b gnt=%b sel=%b y=%b y_valid=%b busy=%b",
             t, req, rst_n, gnt, {s1, s0}, y, y_valid, busy);
  endtask

  // Drive one cycle of stimulus, queue the state expected after the next edge, then compare.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] es, input string t);
    exp_t e;
    rst_n = r;
    req   = rq;
    e.gnt = eg;
    e.sel = es;
    sb_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a = 2'b00; b = 2'b01; c = 2'b10; d = 2'b11;
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;

    // Reset with all requests asserted.
    step(1'b0, 4'b1111, 4'b0000, 2'd0, "reset0");
    step(1'b0, 4'b1111, 4'b0000, 2'd0, "reset1");

    // Single requester 2 for 10 cycles.
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0100, 4'b0100, 2'd2, "single");
    step(1'b1, 4'b0000, 4'b0000, 2'd2, "idle_a");

    // Full contention from last owner 2: owners 3,0,1,2,3, four cycles each.
    for (int k = 0; k < 20; k++) begin
      logic [1:0] own;
      own = 2'((3 + k / 4) % 4);
      step(1'b1, 4'b1111, 4'(1) << own, own, "contend");
    end
    step(1'b1, 4'b0000, 4'b0000, 2'd3, "idle_b");

    // Early release: owner 1 drops while 3 waits.
    step(1'b1, 4'b0010, 4'b0010, 2'd1, "own1");
    step(1'b1, 4'b1010, 4'b0010, 2'd1, "own1_wait3");
    step(1'b1, 4'b1000, 4'b1000, 2'd3, "handover");
    step(1'b1, 4'b0000, 4'b0000, 2'd3, "idle_c");

    // Release with none pending, then wrap from last owner 1 to requester 0.
    step(1'b1, 4'b0010, 4'b0010, 2'd1, "own1_b");
    step(1'b1, 4'b0000, 4'b0000, 2'd1, "idle_d");
    step(1'b1, 4'b0011, 4'b0001, 2'd0, "wrap");

    // Lone owner saturates hold, so a newcomer rotates in on the very next edge.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, 4'b0001, 2'd0, "lone0");
    step(1'b1, 4'b0101, 4'b0100, 2'd2, "sat_rot");

    // Reset mid-grant, then requester 3 alone.
    step(1'b0, 4'b0101, 4'b0000, 2'd0, "rst_mid");
    step(1'b1, 4'b1000, 4'b1000, 2'd3, "post_rst");
    step(1'b1, 4'b0000, 4'b0000, 2'd3, "idle_e");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
